instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving instruction buffer entries and the maximum of outstanding requests plus buffered entries.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; port list follows.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 redirect_valid  input  1  taken branch/jump from the core; restart fetch.
REQ-007 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  instruction memory accepts request.
REQ-010 imem_req_addr  output  32  word-aligned fetch address.
REQ-011 imem_rsp_valid  input  1  in-order instruction return, one per accepted request, latency >= 1 cycle.
REQ-012 imem_rsp_data  input  32  returned instruction word.
REQ-013 if_valid  output  1  if_pc/if_instr valid to the decode/execute stage.
REQ-014 if_ready  input  1  consumer accepts current instruction.
REQ-015 if_pc  output  32  address of presented instruction.
REQ-016 if_instr  output  32  presented instruction word.

Function
REQ-017 fetch_pc SHALL advance by 4 on each accepted request (imem_req_valid && imem_req_ready), wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-018 imem_req_valid SHALL be 1 iff outstanding + occupancy < DEPTH and redirect_valid == 0; imem_req_addr = fetch_pc.
REQ-019 imem_req_valid and imem_req_addr SHALL hold stable while valid and not ready, unless redirect_valid asserts.
REQ-020 Each non-dropped response SHALL be written to the FIFO with its request address; it appears on if_valid no earlier than the cycle after imem_rsp_valid (no bypass).
REQ-021 FIFO pop occurs on if_valid && if_ready; simultaneous push and pop SHALL be legal at any occupancy, including full.
REQ-022 Credit rule (REQ-018) SHALL guarantee no overflow; a response arriving with the FIFO full and no pop is a protocol error, flagged by an assertion only.
REQ-023 if_pc/if_instr SHALL hold stable while if_valid && !if_ready.
REQ-024 FSM states: FETCH (responses enqueued) and DROP (responses discarded while drop_cnt > 0).
REQ-025 On redirect_valid (any state): FIFO flushed, fetch_pc <= {redirect_pc[31:2],2'b00}, drop_cnt <= outstanding minus (1 if imem_rsp_valid that cycle), state <= DROP if that value > 0 else FETCH.
REQ-026 A response arriving in the redirect cycle SHALL be discarded.
REQ-027 In DROP, each imem_rsp_valid decrements drop_cnt; reaching 0 transitions to FETCH; new requests remain permitted in DROP.
REQ-028 if_valid SHALL be 0 in the cycle after redirect_valid.
REQ-029 outstanding counter SHALL be width clog2(DEPTH)+1, incremented on accepted request, decremented on response, both in one cycle leaves it unchanged.

Reset
REQ-030 On rst: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop_cnt = 0, state = FETCH, if_valid = 0, imem_req_valid = 0 during reset cycle.
REQ-031 rst SHALL override redirect_valid; responses to requests issued before reset are the memory's responsibility to cancel.

Structure
REQ-032 DEPTH/RESET_PC defaults, FSM state encoding and the 32-bit word-size constant SHALL live in a shared package riscv_pkg.
REQ-033 The buffer SHALL be one sub-module fetch_fifo (storage {pc,instr}, push/pop/flush, full/empty/count); FSM, counters and PC logic stay in instr_fetch_unit.

Verification
REQ-034 Reset, imem_req_ready=1, 1-cycle rsp, if_ready=1 -> requests 0x0,0x4,0x8,... and if_pc sequence 0x0,0x4,0x8 in order, one per cycle in steady state.
REQ-035 if_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; if_pc holds 0x0; releasing if_ready resumes fetch at 0x10.
REQ-036 3 requests outstanding (rsp latency 3), redirect_pc=0x103 -> next request addr 0x100, those 3 responses dropped, first if_pc=0x100.
REQ-037 Redirect same cycle as a response with outstanding=1 -> drop_cnt=0, state FETCH, no stale instruction delivered.
REQ-038 Redirect to 0xFFFF_FFFC -> request addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst asserted with FIFO full and requests outstanding -> next cycle if_valid=0, imem_req_addr=RESET_PC, outstanding=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction fetch slice: buffer sizing,
// reset address, word size and the fetch FSM encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned IFU_DEPTH = 4;
    localparam logic [XLEN-1:0] IFU_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs; push and pop may coincide at
// any occupancy, and flush empties it in one cycle.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = IFU_DEPTH,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       din,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       dout,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PTR_W-1:0] ptr_t;

    fetch_entry_t mem [DEPTH];
    ptr_t         rd_ptr;
    ptr_t         wr_ptr;
    logic         push_ok;
    logic         pop_ok;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A full buffer still accepts a push when the head leaves the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage is not reset; count/pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-limited instruction fetch: issues word-aligned requests, buffers
// in-order responses, and discards in-flight responses after a redirect.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH    = IFU_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    fetch_state_e    state_q, state_d;
    cnt_t            outstanding_q;
    cnt_t            drop_cnt_q, drop_cnt_d;
    cnt_t            fifo_count;
    logic [CNT_W:0]  credit_used;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            fifo_push, fifo_pop, fifo_flush;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    fifo_din, fifo_dout;

    assign redirect_target = redirect_pc & ~ALIGN_MASK;

    // Every issued request reserves a buffer slot until its entry is consumed.
    assign credit_used    = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CNT_W + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid = !fifo_empty;
    assign if_pc    = fifo_dout.pc;
    assign if_instr = fifo_dout.instr;
    assign fifo_pop = if_valid && if_ready;
    assign fifo_din = '{pc: rsp_pc_q, instr: imem_rsp_data};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        if (redirect_valid) begin
            fifo_flush = 1'b1;
            drop_cnt_d = outstanding_q - cnt_t'(imem_rsp_valid);
            state_d    = (drop_cnt_d != '0) ? ST_DROP : ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH: fifo_push = imem_rsp_valid && (!fifo_full || fifo_pop);
                ST_DROP: begin
                    if (imem_rsp_valid) begin
                        drop_cnt_d = drop_cnt_q - cnt_t'(1);
                        if (drop_cnt_d == '0) state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            drop_cnt_q    <= '0;
            outstanding_q <= '0;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
        end else begin
            state_q       <= state_d;
            drop_cnt_q    <= drop_cnt_d;
            outstanding_q <= outstanding_q + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
            // Responses are in order, so the next kept response belongs to rsp_pc_q.
            if (redirect_valid) begin
                fetch_pc_q <= redirect_target;
                rsp_pc_q   <= redirect_target;
            end else begin
                if (req_fire)  fetch_pc_q <= fetch_pc_q + WORD_BYTES;
                if (fifo_push) rsp_pc_q   <= rsp_pc_q + WORD_BYTES;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(state_q == ST_FETCH && !redirect_valid && imem_rsp_valid && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-configurable memory model
// feeds responses; expected {pc, instr} pairs are queued at request acceptance.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        int          due;
    } mem_t;

    exp_t exp_q[$];
    mem_t mem_q[$];

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          n_req   = 0;
    int          n_out   = 0;
    int          lat     = 1;
    logic [31:0] exp_pc;
    logic        prev_redirect = 1'b0;

    logic        drv_rst         = 1'b1;
    logic        drv_redirect    = 1'b0;
    logic [31:0] drv_redirect_pc = '0;
    logic        drv_req_ready   = 1'b0;
    logic        drv_if_ready    = 1'b0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // One clock cycle: drive at negedge, settle, score, then let the posedge commit.
    task automatic step();
        exp_t e;
        @(negedge clk);
        rst            = drv_rst;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        imem_req_ready = drv_req_ready;
        if_ready       = drv_if_ready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (drv_rst) begin
            mem_q.delete();
        end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].instr;
            void'(mem_q.pop_front());
        end
        #1;
        if (drv_rst) begin
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            exp_q.delete();
            exp_pc        = IFU_RESET_PC;
            prev_redirect = 1'b0;
        end else begin
            if (prev_redirect) check("if_valid_after_redir", {31'b0, if_valid}, 32'd0);
            if (if_valid && if_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("if_unexpected", if_pc, 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                end
            end
            if (drv_redirect) begin
                check("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
                exp_q.delete();
                exp_pc = drv_redirect_pc & 32'hFFFF_FFFC;
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                mem_q.push_back('{instr: instr_of(imem_req_addr), due: cyc + lat});
                exp_q.push_back('{pc: exp_pc, instr: instr_of(exp_pc)});
                exp_pc = exp_pc + 32'd4;
                n_req++;
            end
            prev_redirect = drv_redirect;
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_rst       = 1'b1;
        drv_redirect  = 1'b0;
        drv_req_ready = 1'b0;
        drv_if_ready  = 1'b0;
        step();
        step();
        drv_rst = 1'b0;
    endtask

    task automatic drain();
        logic done = 1'b0;
        drv_req_ready = 1'b0;
        drv_if_ready  = 1'b1;
        drv_redirect  = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && (mem_q.size() == 0);
        end
        check("drain_done", {31'b0, done}, 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;

        // Streaming with 1-cycle memory and an always-ready consumer.
        do_reset();
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        step();
        check("reset_if_valid", {31'b0, if_valid}, 32'd0);
        step();
        check("no_bypass", {31'b0, if_valid}, 32'd0);
        n_out = 0;
        for (int i = 0; i < 10; i++) step();
        check("steady_rate", n_out, 32'd10);
        drain();

        // Stalled consumer: credits cap issue at DEPTH, head stays put.
        do_reset();
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b0;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_valid) check("stall_hold_pc", if_pc, 32'h0);
        end
        check("stall_req_count", n_req, 32'd4);
        check("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        drv_if_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        drain();

        // Redirect with three requests in flight, 3-cycle memory.
        do_reset();
        lat = 3; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0103;
        step();
        drv_redirect = 1'b0;
        n_req = 0; n_out = 0;
        step();
        check("redir_addr", imem_req_addr, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step();
        drain();
        check("redir_deliver_count", n_out, n_req);

        // Redirect coincides with the only outstanding response.
        do_reset();
        lat = 2; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        step();
        drv_req_ready = 1'b0;
        step();
        drv_redirect = 1'b1; drv_redirect_pc = 32'h0000_0200;
        step();
        drv_redirect = 1'b0; drv_req_ready = 1'b1;
        n_req = 0; n_out = 0;
        for (int i = 0; i < 6; i++) step();
        drain();
        check("same_cycle_count", n_out, n_req);

        // Redirect to the top word: fetch wraps to zero.
        lat = 1; drv_req_ready = 1'b1; drv_if_ready = 1'b1;
        drv_redirect = 1'b1; drv_redirect_pc = 32'hFFFF_FFFC;
        step();
        drv_redirect = 1'b0;
        step();
        check("wrap_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_addr_lo", imem_req_addr, 32'h0000_0000);
        for (int i = 0; i < 3; i++) step();
        drain();

        // Reset while entries are buffered and requests are in flight.
        do_reset();
        lat = 3; drv_req_ready = 1'b1; drv_if_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        n_req = 0;
        step();
        check("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        check("midrst_addr", imem_req_addr, IFU_RESET_PC);
        for (int i = 0; i < 9; i++) step();
        check("midrst_credits", n_req, 32'd4);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
